// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults, the $0 index and port-slice helpers for the multi-port register file.
package regfile_mp_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;
   function automatic int lo(input int i, input int w);
      return i * w;
   endfunction
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: per-register pending bits; issue sets, writeback clears, flush clears all.
module regfile_mp_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NWR    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NWR-1:0]          wen,
   input  logic [NWR*ADDR_W-1:0]   wa,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr,
   input  logic                    flush,
   output logic [2**ADDR_W-1:0]    pend,
   output logic                    pend_any
);
   logic [2**ADDR_W-1:0] pend_q, pend_d;
   // Issue is applied last so a new producer beats both flush and writeback.
   always_comb begin
      pend_d = flush ? '0 : pend_q;
      for (int j = 0; j < NWR; j++)
         if (wen[j]) pend_d[wa[lo(j, ADDR_W) +: ADDR_W]] = 1'b0;
      if (iss_en && iss_addr != ADDR_W'(REG_ZERO)) pend_d[iss_addr] = 1'b1;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) pend_q <= '0;
      else        pend_q <= pend_d;
   assign pend     = pend_q;
   assign pend_any = |pend_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write GPR file with write-through bypass, pending scoreboard and commit counter.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int CNT_W  = 32,
   parameter int TRACE  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD*ADDR_W-1:0] ra,
   output logic [NRD*DATA_W-1:0] rd,
   output logic [NRD-1:0]        rd_pend,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*ADDR_W-1:0] wa,
   input  logic [NWR*DATA_W-1:0] wd,
   input  logic [NWR*32-1:0]     wpc,
   input  logic                  iss_en,
   input  logic [ADDR_W-1:0]     iss_addr,
   input  logic                  flush,
   output logic                  pend_any,
   output logic [CNT_W-1:0]      wr_cnt
);
   localparam int DEPTH = 2 ** ADDR_W;
   logic [NWR-1:0]    wen;
   logic [DEPTH-1:0]  pend;
   logic [DATA_W-1:0] rf_q [DEPTH];
   logic [DATA_W-1:0] rf_d [DEPTH];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W:0]    sum;
   // The write trace is a simulation-side feature; wpc and TRACE are kept only for interface compatibility.
   logic unused_trace;
   assign unused_trace = ^wpc & (TRACE != 0);
   always_comb begin
      for (int j = 0; j < NWR; j++)
         wen[j] = we[j] && wa[lo(j, ADDR_W) +: ADDR_W] != ADDR_W'(REG_ZERO);
   end
   // Later ports overwrite earlier ones, giving the highest index priority on collisions.
   always_comb begin
      rf_d = rf_q;
      sum  = {1'b0, cnt_q};
      for (int j = 0; j < NWR; j++)
         if (wen[j]) begin
            rf_d[wa[lo(j, ADDR_W) +: ADDR_W]] = wd[lo(j, DATA_W) +: DATA_W];
            sum = sum + (CNT_W+1)'(1);
         end
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) rf_q[k] <= '0;
         cnt_q <= '0;
      end else begin
         rf_q  <= rf_d;
         cnt_q <= cnt_d;
      end
   assign wr_cnt = cnt_q;
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      logic              hit;
      assign a = ra[lo(i, ADDR_W) +: ADDR_W];
      always_comb begin
         v   = rf_q[a];
         hit = 1'b0;
         for (int j = 0; j < NWR; j++)
            if (wen[j] && wa[lo(j, ADDR_W) +: ADDR_W] == a) begin
               v   = wd[lo(j, DATA_W) +: DATA_W];
               hit = 1'b1;
            end
         if (a == ADDR_W'(REG_ZERO)) v = '0;
      end
      assign rd[lo(i, DATA_W) +: DATA_W] = v;
      assign rd_pend[i] = a != ADDR_W'(REG_ZERO) && pend[a] && !hit;
   end
   regfile_mp_scoreboard #(.ADDR_W(ADDR_W), .NWR(NWR)) u_sb (
      .clk      (clk),
      .reset    (reset),
      .wen      (wen),
      .wa       (wa),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .flush    (flush),
      .pend     (pend),
      .pend_any (pend_any)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp (CNT_W=4 to exercise saturation).
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  ra;
   logic [63:0] rd;
   logic [1:0]  rd_pend;
   logic [1:0]  we;
   logic [9:0]  wa;
   logic [63:0] wd;
   logic [63:0] wpc;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        flush;
   logic        pend_any;
   logic [3:0]  wr_cnt;
   int          total = 0;
   int          bad = 0;
   int          cnt_exp = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .CNT_W(4), .TRACE(1)) dut (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_pend(rd_pend),
      .we(we), .wa(wa), .wd(wd), .wpc(wpc),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
      .pend_any(pend_any), .wr_cnt(wr_cnt)
   );

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s no expected value queued, obs=%h", tag, obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, e);
      end
   endtask

   task automatic idle();
      we = '0; iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
      we[p] = 1'b1;
      wa[p*5 +: 5] = a;
      wd[p*32 +: 32] = d;
   endtask

   task automatic tick(input int n);
      @(posedge clk);
      #1;
      cnt_exp = (cnt_exp + n > 15) ? 15 : cnt_exp + n;
   endtask

   initial begin
      reset = 1'b0; ra = '0; wa = '0; wd = '0; wpc = '0;
      idle();
      #2 reset = 1'b1;
      // reset behaviour
      wr(0, 5'd5, 32'h11);
      tick(1);
      idle(); ra[4:0] = 5'd5;
      #1 push(32'h11); chk("pre_reset_rd", rd[31:0]);
      reset = 1'b0;
      #1 cnt_exp = 0;
      push(32'h0); chk("reset_rd", rd[31:0]);
      push(32'h0); chk("reset_cnt", 32'(wr_cnt));
      push(32'h0); chk("reset_pend_any", 32'(pend_any));
      wr(0, 5'd5, 32'h22);
      tick(0);
      idle();
      #1 push(32'h0); chk("reset_hold_rd", rd[31:0]);
      reset = 1'b1;
      #1;
      // bypass
      wr(0, 5'd8, 32'hDEAD); ra[4:0] = 5'd8;
      #1 push(32'hDEAD); chk("bypass_rd", rd[31:0]);
      push(32'h0); chk("bypass_pend", 32'(rd_pend[0]));
      tick(1);
      idle();
      #1 push(32'hDEAD); chk("rf_rd", rd[31:0]);
      // collision
      wr(0, 5'd3, 32'h1); wr(1, 5'd3, 32'h2); ra[9:5] = 5'd3;
      #1 push(32'h2); chk("coll_bypass", rd[63:32]);
      tick(2);
      idle();
      #1 push(32'h2); chk("coll_rf", rd[63:32]);
      push(32'(cnt_exp)); chk("coll_cnt", 32'(wr_cnt));
      // register zero
      wr(1, 5'd0, 32'hFFFF); ra[4:0] = 5'd0; iss_en = 1'b1; iss_addr = 5'd0;
      #1 push(32'h0); chk("r0_bypass", rd[31:0]);
      tick(0);
      idle();
      #1 push(32'h0); chk("r0_rf", rd[31:0]);
      push(32'(cnt_exp)); chk("r0_cnt", 32'(wr_cnt));
      push(32'h0); chk("r0_pend_any", 32'(pend_any));
      // scoreboard
      iss_en = 1'b1; iss_addr = 5'd9; ra[4:0] = 5'd9;
      #1 push(32'h0); chk("iss_pend_early", 32'(rd_pend[0]));
      push(32'h1); push(32'h1);
      tick(0);
      idle();
      #1 chk("iss_pend", 32'(rd_pend[0]));
      chk("iss_pend_any", 32'(pend_any));
      wr(0, 5'd9, 32'h99);
      #1 push(32'h0); chk("wb_pend_bypass", 32'(rd_pend[0]));
      push(32'h99); chk("wb_rd", rd[31:0]);
      push(32'h0); push(32'h0);
      tick(1);
      idle();
      #1 chk("wb_pend", 32'(rd_pend[0]));
      chk("wb_pend_any", 32'(pend_any));
      iss_en = 1'b1; iss_addr = 5'd9; wr(1, 5'd9, 32'h77);
      push(32'h1); push(32'h77);
      tick(1);
      idle();
      #1 chk("iss_wb_pend", 32'(rd_pend[0]));
      chk("iss_wb_rd", rd[31:0]);
      flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4; ra[9:5] = 5'd4;
      push(32'h0); push(32'h1); push(32'h1);
      tick(0);
      idle();
      #1 chk("flush_pend9", 32'(rd_pend[0]));
      chk("flush_pend4", 32'(rd_pend[1]));
      chk("flush_pend_any", 32'(pend_any));
      flush = 1'b1;
      push(32'h0);
      tick(0);
      idle();
      #1 chk("flush_all", 32'(pend_any));
      // saturation
      for (int i = 0; i < 20; i++) begin
         wr(0, 5'd10, 32'(i));
         tick(1);
         if (i == 4) begin
            push(32'(cnt_exp)); chk("cnt_mid", 32'(wr_cnt));
         end
      end
      idle();
      #1 push(32'd15); chk("cnt_sat", 32'(wr_cnt));
      wr(0, 5'd11, 32'h1); wr(1, 5'd12, 32'h2);
      tick(2);
      idle();
      #1 push(32'd15); chk("cnt_hold", 32'(wr_cnt));
      ra[4:0] = 5'd10;
      #1 push(32'd19); chk("last_wr", rd[31:0]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
